// File: rtl/apb_rr_arbiter.sv
// Purpose: round-robin arbiter that shares one APB master port between several single-transfer requesters.
// Latency: accept at T, SETUP at T+1, ACCESS from T+2, response pulse one cycle after ACCESS/ERR ends.
// Backpressure: requesters hold valid until a one-hot ready pulse; responses are never stalled.

package axi2apb;

  // APB request bus (psel is carried separately as a one-hot vector)
  typedef struct packed {
    logic [31:0] paddr;
    logic [2:0]  pprot;
    logic        penable;
    logic        pwrite;
    logic [31:0] pwdata;
    logic [3:0]  pstrb;
  } apb_req_t;

  // APB slave response
  typedef struct packed {
    logic        pready;
    logic [31:0] prdata;
    logic        pslverr;
  } apb_resp_t;

endpackage

module apb_rr_arbiter #(
  parameter int unsigned NoRequesters  = 2,
  parameter int unsigned NoApbSlaves   = 1,
  parameter logic [31:0] APBSlotSize   = 32'h0001_0000,
  parameter int unsigned TimeoutCycles = 256
) (
  input  logic                               apb_clk,
  input  logic                               apb_rst,
  input  logic [NoRequesters-1:0]            req_valid_i,
  output logic [NoRequesters-1:0]            req_ready_o,
  input  logic [NoRequesters-1:0][31:0]      req_addr_i,
  input  logic [NoRequesters-1:0]            req_write_i,
  input  logic [NoRequesters-1:0][31:0]      req_wdata_i,
  input  logic [NoRequesters-1:0][3:0]       req_strb_i,
  input  logic [NoRequesters-1:0][2:0]       req_prot_i,
  output logic [NoRequesters-1:0]            rsp_valid_o,
  output logic [31:0]                        rsp_rdata_o,
  output logic                               rsp_err_o,
  output axi2apb::apb_req_t                  apb_req,
  output logic [NoApbSlaves-1:0]             apb_sel,
  input  axi2apb::apb_resp_t [NoApbSlaves-1:0] apb_resps
);

  localparam int RW        = (NoRequesters > 1) ? $clog2(NoRequesters) : 1;
  localparam int SW        = (NoApbSlaves > 1) ? $clog2(NoApbSlaves) : 1;
  localparam int CW        = $clog2(TimeoutCycles) + 1;
  localparam int SlotShift = $clog2(APBSlotSize);
  localparam logic [CW-1:0] TimeoutLast = CW'(TimeoutCycles - 1);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, ERR} state_e;

  state_e state_q, state_d;

  logic [RW-1:0] ptr_q;
  logic [RW-1:0] grant_q;
  logic [SW-1:0] slot_q;
  logic [CW-1:0] cnt_q;
  logic [31:0]   addr_q;
  logic          write_q;
  logic [31:0]   wdata_q;
  logic [3:0]    strb_q;
  logic [2:0]    prot_q;

  logic [NoRequesters-1:0] rsp_vld_q;
  logic [31:0]             rsp_rdata_q;
  logic                    rsp_err_q;

  logic          gnt_found;
  logic [RW-1:0] gnt_idx;
  logic [31:0]   sel_addr;
  logic [31:0]   slot_full;
  logic          slot_ok;
  logic          timeout;
  axi2apb::apb_resp_t resp_sel;

  // Pick the first pending requester at or after the round-robin pointer
  always_comb begin : p_arb
    int cand;
    gnt_found = 1'b0;
    gnt_idx   = '0;
    cand      = 0;
    for (int i = 0; i < int'(NoRequesters); i++) begin
      cand = (int'(ptr_q) + i) % int'(NoRequesters);
      if (!gnt_found && req_valid_i[RW'(cand)]) begin
        gnt_found = 1'b1;
        gnt_idx   = RW'(cand);
      end
    end
  end

  // Slot decode of the candidate address and selection of the active slave response
  always_comb begin
    sel_addr  = req_addr_i[gnt_idx];
    slot_full = sel_addr >> SlotShift;
    slot_ok   = (slot_full < 32'(NoApbSlaves));
    resp_sel  = apb_resps[slot_q];
    timeout   = (cnt_q == TimeoutLast);
  end

  // FSM state register
  always_ff @(posedge apb_clk) begin
    if (apb_rst) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // FSM next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (gnt_found) state_d = slot_ok ? SETUP : ERR;
      SETUP:   state_d = ACCESS;
      ACCESS:  if (resp_sel.pready || timeout) state_d = IDLE;
      ERR:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs: APB phase signals and the combinational accept pulse
  always_comb begin
    apb_req     = '0;
    apb_sel     = '0;
    req_ready_o = '0;
    case (state_q)
      IDLE: begin
        // Ready is masked during reset so nothing is accepted that the reset would drop
        if (gnt_found && !apb_rst) req_ready_o[gnt_idx] = 1'b1;
      end
      SETUP, ACCESS: begin
        apb_sel[slot_q] = 1'b1;
        apb_req.paddr   = addr_q;
        apb_req.pprot   = prot_q;
        apb_req.pwrite  = write_q;
        apb_req.pwdata  = wdata_q;
        apb_req.pstrb   = strb_q;
        apb_req.penable = (state_q == ACCESS);
      end
      default: ;
    endcase
  end

  // Transfer capture, wait-state counter and response registers
  always_ff @(posedge apb_clk) begin
    if (apb_rst) begin
      ptr_q       <= '0;
      grant_q     <= '0;
      slot_q      <= '0;
      cnt_q       <= '0;
      addr_q      <= '0;
      write_q     <= 1'b0;
      wdata_q     <= '0;
      strb_q      <= '0;
      prot_q      <= '0;
      rsp_vld_q   <= '0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      rsp_vld_q <= '0;
      case (state_q)
        IDLE: begin
          if (gnt_found) begin
            grant_q <= gnt_idx;
            ptr_q   <= RW'((int'(gnt_idx) + 1) % int'(NoRequesters));
            slot_q  <= SW'(slot_full);
            addr_q  <= sel_addr;
            write_q <= req_write_i[gnt_idx];
            wdata_q <= req_wdata_i[gnt_idx];
            strb_q  <= req_strb_i[gnt_idx];
            prot_q  <= req_prot_i[gnt_idx];
            cnt_q   <= '0;
          end
        end
        SETUP: cnt_q <= '0;
        ACCESS: begin
          if (resp_sel.pready) begin
            rsp_vld_q[grant_q] <= 1'b1;
            rsp_rdata_q        <= write_q ? 32'h0 : resp_sel.prdata;
            rsp_err_q          <= resp_sel.pslverr;
          end else if (timeout) begin
            rsp_vld_q[grant_q] <= 1'b1;
            rsp_rdata_q        <= 32'h0;
            rsp_err_q          <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        ERR: begin
          rsp_vld_q[grant_q] <= 1'b1;
          rsp_rdata_q        <= 32'h0;
          rsp_err_q          <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign rsp_valid_o = rsp_vld_q;
  assign rsp_rdata_o = rsp_rdata_q;
  assign rsp_err_o   = rsp_err_q;

endmodule

// File: tb/tb_apb_rr_arbiter.sv
// Purpose: directed self-checking bench for apb_rr_arbiter (2 requesters, 2 slaves, 4-cycle timeout).
// Latency: checks are taken 2 time units after each rising edge.
// Backpressure: a small APB slave model inserts a configurable number of wait states.

module tb_apb_rr_arbiter;

  logic                  apb_clk = 1'b0;
  logic                  apb_rst;
  logic [1:0]            req_valid_i;
  logic [1:0]            req_ready_o;
  logic [1:0][31:0]      req_addr_i;
  logic [1:0]            req_write_i;
  logic [1:0][31:0]      req_wdata_i;
  logic [1:0][3:0]       req_strb_i;
  logic [1:0][2:0]       req_prot_i;
  logic [1:0]            rsp_valid_o;
  logic [31:0]           rsp_rdata_o;
  logic                  rsp_err_o;
  axi2apb::apb_req_t     apb_req;
  logic [1:0]            apb_sel;
  axi2apb::apb_resp_t [1:0] apb_resps;

  int errors = 0;
  int checks = 0;

  // Slave model: pready rises after wait_cfg ACCESS cycles
  int          acc_cnt  = 0;
  int          wait_cfg = 0;
  logic [31:0] slv_rdata0 = 32'h0;
  logic [31:0] slv_rdata1 = 32'h0;
  logic        slv_err = 1'b0;

  always #5 apb_clk = ~apb_clk;

  always @(posedge apb_clk) acc_cnt <= apb_req.penable ? acc_cnt + 1 : 0;

  assign apb_resps[0] = {apb_sel[0] & apb_req.penable & (acc_cnt == wait_cfg), slv_rdata0, slv_err};
  assign apb_resps[1] = {apb_sel[1] & apb_req.penable & (acc_cnt == wait_cfg), slv_rdata1, slv_err};

  apb_rr_arbiter #(
    .NoRequesters (2),
    .NoApbSlaves  (2),
    .APBSlotSize  (32'h0001_0000),
    .TimeoutCycles(4)
  ) dut (
    .apb_clk    (apb_clk),
    .apb_rst    (apb_rst),
    .req_valid_i(req_valid_i),
    .req_ready_o(req_ready_o),
    .req_addr_i (req_addr_i),
    .req_write_i(req_write_i),
    .req_wdata_i(req_wdata_i),
    .req_strb_i (req_strb_i),
    .req_prot_i (req_prot_i),
    .rsp_valid_o(rsp_valid_o),
    .rsp_rdata_o(rsp_rdata_o),
    .rsp_err_o  (rsp_err_o),
    .apb_req    (apb_req),
    .apb_sel    (apb_sel),
    .apb_resps  (apb_resps)
  );

  task automatic cyc();
    @(posedge apb_clk);
    #2;
  endtask

  task automatic set_req(input int r, input logic [31:0] addr, input logic wr,
                         input logic [31:0] wdata, input logic [3:0] strb, input logic [2:0] prot);
    req_addr_i[r]  = addr;
    req_write_i[r] = wr;
    req_wdata_i[r] = wdata;
    req_strb_i[r]  = strb;
    req_prot_i[r]  = prot;
  endtask

  task automatic test_reset();
    apb_rst     = 1'b1;
    req_valid_i = 2'b01;
    cyc();
    cyc();
    checks++; if (req_ready_o !== 2'b00) begin errors++; $display("FAIL reset_ready: got %b want 00", req_ready_o); end
    checks++; if (apb_sel !== 2'b00) begin errors++; $display("FAIL reset_sel: got %b want 00", apb_sel); end
    checks++; if (apb_req !== '0) begin errors++; $display("FAIL reset_apb_req: got %h want 0", apb_req); end
    checks++; if (rsp_valid_o !== 2'b00) begin errors++; $display("FAIL reset_rsp_valid: got %b want 00", rsp_valid_o); end
    checks++; if ({rsp_err_o, rsp_rdata_o} !== 33'h0) begin errors++; $display("FAIL reset_rsp_data: got %b/%h want 0/0", rsp_err_o, rsp_rdata_o); end
    apb_rst     = 1'b0;
    req_valid_i = 2'b00;
    #1;
  endtask

  task automatic test_single_write();
    wait_cfg = 0;
    set_req(0, 32'h0001_0004, 1'b1, 32'hDEAD_BEEF, 4'hF, 3'b010);
    req_valid_i = 2'b01;
    #1;
    checks++; if (req_ready_o !== 2'b01) begin errors++; $display("FAIL wr_accept: got %b want 01", req_ready_o); end
    checks++; if (apb_sel !== 2'b00) begin errors++; $display("FAIL wr_idle_sel: got %b want 00", apb_sel); end
    cyc();
    req_valid_i = 2'b00;
    set_req(0, 32'h0, 1'b0, 32'h0, 4'h0, 3'b000);
    checks++; if ({apb_sel, apb_req.penable} !== 3'b100) begin errors++; $display("FAIL wr_setup: got sel=%b pen=%b want sel=10 pen=0", apb_sel, apb_req.penable); end
    checks++; if ({apb_req.paddr, apb_req.pwdata, apb_req.pstrb, apb_req.pwrite, apb_req.pprot} !== {32'h0001_0004, 32'hDEAD_BEEF, 4'hF, 1'b1, 3'b010})
      begin errors++; $display("FAIL wr_setup_bus: got addr=%h data=%h strb=%h wr=%b prot=%b", apb_req.paddr, apb_req.pwdata, apb_req.pstrb, apb_req.pwrite, apb_req.pprot); end
    cyc();
    checks++; if ({apb_sel, apb_req.penable, rsp_valid_o} !== 5'b10100) begin errors++; $display("FAIL wr_access: got sel=%b pen=%b rsp=%b want 10/1/00", apb_sel, apb_req.penable, rsp_valid_o); end
    checks++; if (apb_req.paddr !== 32'h0001_0004) begin errors++; $display("FAIL wr_access_addr: got %h want 00010004", apb_req.paddr); end
    cyc();
    checks++; if ({rsp_valid_o, rsp_err_o} !== 3'b010) begin errors++; $display("FAIL wr_rsp: got valid=%b err=%b want 01/0", rsp_valid_o, rsp_err_o); end
    checks++; if ({apb_sel, apb_req} !== '0) begin errors++; $display("FAIL wr_idle_after: got sel=%b req=%h want 0", apb_sel, apb_req); end
  endtask

  task automatic test_read_wait();
    wait_cfg   = 3;
    slv_rdata0 = 32'h1234_5678;
    slv_rdata1 = 32'hAAAA_5555;
    set_req(1, 32'h0000_0040, 1'b0, 32'h0, 4'h0, 3'b000);
    req_valid_i = 2'b10;
    #1;
    checks++; if (req_ready_o !== 2'b10) begin errors++; $display("FAIL rd_accept: got %b want 10", req_ready_o); end
    cyc();
    req_valid_i = 2'b00;
    checks++; if ({apb_sel, apb_req.penable} !== 3'b010) begin errors++; $display("FAIL rd_setup: got sel=%b pen=%b want 01/0", apb_sel, apb_req.penable); end
    for (int c = 2; c <= 5; c++) begin
      cyc();
      checks++; if ({apb_sel, apb_req.penable, rsp_valid_o} !== 5'b01100) begin errors++; $display("FAIL rd_access_T%0d: got sel=%b pen=%b rsp=%b want 01/1/00", c, apb_sel, apb_req.penable, rsp_valid_o); end
    end
    cyc();
    checks++; if ({rsp_valid_o, rsp_err_o, rsp_rdata_o} !== {2'b10, 1'b0, 32'h1234_5678}) begin errors++; $display("FAIL rd_rsp: got valid=%b err=%b data=%h want 10/0/12345678", rsp_valid_o, rsp_err_o, rsp_rdata_o); end
    wait_cfg = 0;
  endtask

  task automatic test_contention();
    logic [1:0] exp_g;
    logic [1:0] prev_g;
    wait_cfg = 0;
    prev_g   = 2'b00;
    set_req(0, 32'h0000_0100, 1'b1, 32'h0000_0A0A, 4'hF, 3'b000);
    set_req(1, 32'h0001_0200, 1'b1, 32'h0000_0B0B, 4'h3, 3'b001);
    req_valid_i = 2'b11;
    #1;
    for (int k = 0; k < 4; k++) begin
      exp_g = (k % 2 == 0) ? 2'b01 : 2'b10;
      checks++; if (req_ready_o !== exp_g) begin errors++; $display("FAIL cont_grant%0d: got %b want %b", k, req_ready_o, exp_g); end
      if (k > 0) begin
        checks++; if (rsp_valid_o !== prev_g) begin errors++; $display("FAIL cont_rsp%0d: got %b want %b", k, rsp_valid_o, prev_g); end
      end
      prev_g = exp_g;
      cyc();
      if (k == 3) req_valid_i = 2'b00;
      checks++; if (req_ready_o !== 2'b00) begin errors++; $display("FAIL cont_gap_a%0d: got %b want 00", k, req_ready_o); end
      cyc();
      checks++; if (req_ready_o !== 2'b00) begin errors++; $display("FAIL cont_gap_b%0d: got %b want 00", k, req_ready_o); end
      cyc();
    end
    checks++; if (rsp_valid_o !== 2'b10) begin errors++; $display("FAIL cont_rsp_last: got %b want 10", rsp_valid_o); end
  endtask

  task automatic test_decode_err();
    slv_err = 1'b0;
    set_req(0, 32'h0002_0000, 1'b0, 32'h0, 4'h0, 3'b000);
    req_valid_i = 2'b01;
    #1;
    checks++; if (req_ready_o !== 2'b01) begin errors++; $display("FAIL dec_accept: got %b want 01", req_ready_o); end
    cyc();
    req_valid_i = 2'b00;
    checks++; if ({apb_sel, apb_req} !== '0) begin errors++; $display("FAIL dec_err_bus: got sel=%b req=%h want 0", apb_sel, apb_req); end
    cyc();
    checks++; if ({rsp_valid_o, rsp_err_o, rsp_rdata_o, apb_sel} !== {2'b01, 1'b1, 32'h0, 2'b00}) begin errors++; $display("FAIL dec_rsp: got valid=%b err=%b data=%h sel=%b want 01/1/0/00", rsp_valid_o, rsp_err_o, rsp_rdata_o, apb_sel); end
  endtask

  task automatic test_timeout();
    wait_cfg = 1000;
    set_req(1, 32'h0001_0010, 1'b0, 32'h0, 4'h0, 3'b000);
    req_valid_i = 2'b10;
    #1;
    checks++; if (req_ready_o !== 2'b10) begin errors++; $display("FAIL to_accept: got %b want 10", req_ready_o); end
    cyc();
    req_valid_i = 2'b00;
    checks++; if ({apb_sel, apb_req.penable} !== 3'b100) begin errors++; $display("FAIL to_setup: got sel=%b pen=%b want 10/0", apb_sel, apb_req.penable); end
    for (int c = 2; c <= 5; c++) begin
      cyc();
      checks++; if ({apb_sel, apb_req.penable, rsp_valid_o} !== 5'b10100) begin errors++; $display("FAIL to_access_T%0d: got sel=%b pen=%b rsp=%b want 10/1/00", c, apb_sel, apb_req.penable, rsp_valid_o); end
    end
    cyc();
    checks++; if ({apb_sel, apb_req.penable} !== 3'b000) begin errors++; $display("FAIL to_release: got sel=%b pen=%b want 00/0", apb_sel, apb_req.penable); end
    checks++; if ({rsp_valid_o, rsp_err_o, rsp_rdata_o} !== {2'b10, 1'b1, 32'h0}) begin errors++; $display("FAIL to_rsp: got valid=%b err=%b data=%h want 10/1/0", rsp_valid_o, rsp_err_o, rsp_rdata_o); end
    // A new request is accepted in the same cycle as the timeout response
    wait_cfg = 0;
    set_req(0, 32'h0000_0008, 1'b1, 32'h5555_0000, 4'h1, 3'b000);
    req_valid_i = 2'b01;
    #1;
    checks++; if (req_ready_o !== 2'b01) begin errors++; $display("FAIL to_next_accept: got %b want 01", req_ready_o); end
    cyc();
    req_valid_i = 2'b00;
    cyc();
    cyc();
    checks++; if ({rsp_valid_o, rsp_err_o} !== 3'b010) begin errors++; $display("FAIL to_next_rsp: got valid=%b err=%b want 01/0", rsp_valid_o, rsp_err_o); end
  endtask

  task automatic test_reset_mid();
    wait_cfg = 1000;
    set_req(0, 32'h0000_0004, 1'b0, 32'h0, 4'h0, 3'b000);
    req_valid_i = 2'b01;
    #1;
    checks++; if (req_ready_o !== 2'b01) begin errors++; $display("FAIL rst_accept: got %b want 01", req_ready_o); end
    cyc();
    req_valid_i = 2'b00;
    cyc();
    cyc();
    checks++; if ({apb_sel, apb_req.penable} !== 3'b011) begin errors++; $display("FAIL rst_in_access: got sel=%b pen=%b want 01/1", apb_sel, apb_req.penable); end
    apb_rst = 1'b1;
    cyc();
    apb_rst = 1'b0;
    checks++; if ({apb_sel, apb_req, req_ready_o, rsp_valid_o} !== '0) begin errors++; $display("FAIL rst_outputs: got sel=%b req=%h rdy=%b rsp=%b want 0", apb_sel, apb_req, req_ready_o, rsp_valid_o); end
    cyc();
    checks++; if (rsp_valid_o !== 2'b00) begin errors++; $display("FAIL rst_no_rsp: got %b want 00", rsp_valid_o); end
    wait_cfg = 0;
    set_req(1, 32'h0000_0020, 1'b1, 32'h1, 4'hF, 3'b000);
    req_valid_i = 2'b11;
    #1;
    checks++; if (req_ready_o !== 2'b01) begin errors++; $display("FAIL rst_ptr_grant: got %b want 01", req_ready_o); end
    cyc();
    req_valid_i = 2'b00;
    cyc();
    cyc();
    checks++; if ({rsp_valid_o, rsp_err_o, rsp_rdata_o} !== {2'b01, 1'b0, 32'h1234_5678}) begin errors++; $display("FAIL rst_next_rsp: got valid=%b err=%b data=%h want 01/0/12345678", rsp_valid_o, rsp_err_o, rsp_rdata_o); end
  endtask

  initial begin
    apb_rst     = 1'b1;
    req_valid_i = '0;
    req_addr_i  = '0;
    req_write_i = '0;
    req_wdata_i = '0;
    req_strb_i  = '0;
    req_prot_i  = '0;
    test_reset();
    test_single_write();
    test_read_wait();
    test_contention();
    test_decode_err();
    test_timeout();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at time %0t", $time);
    $fatal(1);
  end

endmodule

// File: doc/apb_rr_arbiter.md
# apb_rr_arbiter

Round-robin arbiter and APB master sequencer that shares the single APB request bus (`axi2apb::apb_req_t` plus one-hot `apb_sel`) between several single-transfer requesters, e.g. the AXI-Lite bridge path and a boot/debug config engine. It runs entirely in the APB clock domain. For each transfer it decodes the target slot, drives the SETUP/ACCESS phases and waits for `pready`. It returns read data and error status to the granted requester, and reports decode errors and timeouts locally without touching the bus.

## Interface
- `NoRequesters`, 2: number of requesters (≥1).
- `NoApbSlaves`, 1: number of APB slaves / `apb_sel` bits.
- `APBSlotSize`, 32'h0001_0000: bytes per slave slot; power of two. Slot i = [i·APBSlotSize, (i+1)·APBSlotSize).
- `TimeoutCycles`, 256: max ACCESS cycles waiting for `pready` (≥2).

Ports:
- `apb_clk` in 1: clock.
- `apb_rst` in 1: synchronous, active-high reset.
- `req_valid_i` in [NoRequesters]: request pending; held until accepted.
- `req_ready_o` out [NoRequesters]: one-hot accept pulse.
- `req_addr_i` in [NoRequesters][32]: byte address.
- `req_write_i` in [NoRequesters]: 1 = write.
- `req_wdata_i` in [NoRequesters][32]: write data.
- `req_strb_i` in [NoRequesters][4]: write strobes.
- `req_prot_i` in [NoRequesters][3]: protection.
- `rsp_valid_o` out [NoRequesters]: one-hot, one-cycle response pulse; no backpressure.
- `rsp_rdata_o` out 32: read data (0 for writes and errors).
- `rsp_err_o` out 1: pslverr, decode error or timeout.
- `apb_req` out `axi2apb::apb_req_t`: paddr, pprot, penable, pwrite, pwdata, pstrb.
- `apb_sel` out [NoApbSlaves]: one-hot psel.
- `apb_resps` in `axi2apb::apb_resp_t` [NoApbSlaves]: pready, prdata, pslverr.

## Operation
- FSM states: IDLE, SETUP, ACCESS, ERR.
- IDLE:
  - If any `req_valid_i` is high, grant the first requester at or after `ptr` (wrapping) and assert its `req_ready_o` combinationally in that cycle.
  - Register addr/write/wdata/strb/prot and grant index; set `ptr` = grant+1 mod NoRequesters.
  - Decode idx = addr / APBSlotSize. If idx < NoApbSlaves, go to SETUP; otherwise go to ERR.
- SETUP: `apb_sel[idx]`=1, penable=0; paddr = full registered address. Go to ACCESS.
- ACCESS:
  - `apb_sel[idx]`=1, penable=1; only `apb_resps[idx]` is sampled.
  - On pready=1: register rdata (prdata if read, else 0) and err = pslverr, then go to IDLE.
  - If the timeout counter reaches TimeoutCycles-1 without pready: register rdata=0, err=1, then go to IDLE.
- ERR: drive no APB activity for one cycle; register rdata=0, err=1; go to IDLE.
- `rsp_valid_o[grant]` pulses in the cycle after a transfer leaves ACCESS or ERR. That cycle is IDLE, so a new request can be accepted in the same cycle.
- APB outputs (paddr, pprot, pwrite, pwdata, pstrb) hold their registered values through SETUP and ACCESS. They are zero in IDLE and ERR.
- Timeout counter: clears on SETUP entry and increments each ACCESS cycle. Its width is clog2(TimeoutCycles)+1 and it must not wrap.
- Requester arguments are don't-care except in the accept cycle.
- Reset: state IDLE, `ptr`=0 (requester 0 wins first), counter 0. All outputs are 0, including `apb_req`, `apb_sel`, `req_ready_o`, `rsp_*`. A transfer in flight is abandoned with no response, and `apb_sel` drops in the cycle after reset is sampled.

## Timing
- Zero-wait transfer: accept at T, SETUP at T+1, ACCESS at T+2 (pready=1), `rsp_valid` at T+3, next accept possible at T+3. Peak rate is 1 transfer per 3 cycles.
- Each wait state adds 1 cycle.
- Decode error: accept at T, ERR at T+1, `rsp_valid` at T+2.
- Timeout: ACCESS lasts exactly TimeoutCycles cycles; `rsp_valid` follows in the next cycle.
- A requester whose `req_valid_i` goes high while another transfer is active is served within NoRequesters grants.

## Test plan
- Single write, NoApbSlaves=2: req0 writes addr 0x0001_0004, data 0xDEADBEEF, strb 0xF, pready tied 1.
  - Expect: `apb_sel`=2'b10, paddr=0x0001_0004, penable 0→1 over 2 cycles, `rsp_valid_o[0]` at T+3, err=0.
- Read with 3 wait states: slave 0 returns prdata 0x1234_5678 on the 4th ACCESS cycle.
  - Expect: `rsp_rdata_o`=0x1234_5678 and rsp at T+6.
- Contention: req0 and req1 held valid continuously for 4 transfers.
  - Expect: grants 0,1,0,1, one `req_ready_o` per transfer, accepts 3 cycles apart.
- Decode error: NoApbSlaves=1, addr 0x0002_0000.
  - Expect: `apb_sel` stays 0, `rsp_err_o`=1, rdata=0, rsp at T+2.
- Timeout: TimeoutCycles=4, pready held 0.
  - Expect: exactly 4 ACCESS cycles, then psel=0, rsp err=1; a following request proceeds normally.
- Reset mid-ACCESS: assert `apb_rst` for 1 cycle during wait states.
  - Expect: all outputs 0 the next cycle, no `rsp_valid`, and the next grant goes to requester 0.
